lfsr_galois_param: RTL and testbench

// - Parametrised Galois LFSR; generalises the fixed 6-bit x^6+x^3+1 shifter.
// - Adds parallel seed load, step enable and all-zero lock-up recovery.
// - Adds on-line period measurement with a wrap pulse.
// - Used as pattern source / BIST generator beside datapath blocks; optionally as MISR signature compactor.

---
 rtl/lfsr_pkg.sv | 36 +++
 rtl/lfsr_period_ctr.sv | 61 ++++++
 rtl/lfsr_galois_param.sv | 104 ++++++++++
 tb/tb_lfsr_galois_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: Galois step function plus the legacy 6-bit x^6+x^3+1 polynomial and seed.
package lfsr_pkg;

  localparam int         LFSR_MAX_W = 64;
  localparam logic [5:0] LFSR6_POLY = 6'h08;
  localparam logic [5:0] LFSR6_SEED = 6'h3F;

  // One Galois step over the low `width` bits; bit 0 of poly never participates.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_galois_next(
    input logic [LFSR_MAX_W-1:0] q,
    input logic [LFSR_MAX_W-1:0] poly,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] g;
    logic                  msb;
    msb = 1'b0;
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if (i == width - 1) begin
        msb = q[i];
      end else begin
        msb = msb;
      end
    end
    g    = '0;
    g[0] = msb;
    for (int i = 1; i < LFSR_MAX_W; i++) begin
      if (i < width) begin
        g[i] = q[i-1] ^ (poly[i] & msb);
      end else begin
        g[i] = 1'b0;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/lfsr_period_ctr.sv
// Saturating step counter since the last reference point, with captured period and wrap pulse.
module lfsr_period_ctr
  import lfsr_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic             hit_i,
  output logic [CNT_W-1:0] period_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_inc_s;

  // A saturated count stays saturated, so the next period reads all-ones.
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      if (hit_i) begin
        period_d = cnt_inc_s;
        cnt_d    = '0;
        wrap_d   = 1'b1;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
    end
  end

  assign period_o = period_q;
  assign wrap_o   = wrap_q;

endmodule

// File: rtl/lfsr_galois_param.sv
// Parametrised Galois LFSR with seed load, lock-up recovery and period measurement.
// Define LFSR_MISR_EN to add din_i and fold it into every step (signature compactor mode).
module lfsr_galois_param
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR6_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR6_SEED),
  parameter int               CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
`ifdef LFSR_MISR_EN
  input  logic [WIDTH-1:0] din_i,
`endif
  output logic [WIDTH-1:0] q_o,
  output logic             lockup_o,
  output logic             wrap_o,
  output logic [CNT_W-1:0] period_o
);

  logic [WIDTH-1:0]      q_q, q_d;
  logic [WIDTH-1:0]      ref_q, ref_d;
  logic                  lockup_q, lockup_d;
  logic [LFSR_MAX_W-1:0] q_ext_s, poly_ext_s, g_full_s;
  logic [WIDTH-1:0]      step_s;
  logic                  lock_s, clr_s, adv_s, hit_s;
  logic                  unused_g_s;

  always_comb begin
    q_ext_s                 = '0;
    q_ext_s[WIDTH-1:0]      = q_q;
    poly_ext_s              = '0;
    poly_ext_s[WIDTH-1:0]   = POLY;
    g_full_s                = lfsr_galois_next(q_ext_s, poly_ext_s, WIDTH);
  end

  assign unused_g_s = ^g_full_s;

`ifdef LFSR_MISR_EN
  // In compactor mode lock-up is judged on the value that would be stored.
  assign step_s = g_full_s[WIDTH-1:0] ^ din_i;
  assign lock_s = (step_s == '0);
`else
  assign step_s = g_full_s[WIDTH-1:0];
  assign lock_s = (q_q == '0);
`endif

  always_comb begin
    q_d      = q_q;
    ref_d    = ref_q;
    lockup_d = 1'b0;
    clr_s    = 1'b0;
    adv_s    = 1'b0;
    hit_s    = 1'b0;
    if (ld_i) begin
      q_d   = ld_val_i;
      ref_d = ld_val_i;
      clr_s = 1'b1;
    end else if (en_i && lock_s) begin
      q_d      = SEED;
      ref_d    = SEED;
      clr_s    = 1'b1;
      lockup_d = 1'b1;
    end else if (en_i) begin
      q_d   = step_s;
      adv_s = 1'b1;
      hit_s = (step_s == ref_q);
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q      <= SEED;
      ref_q    <= SEED;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      ref_q    <= ref_d;
      lockup_q <= lockup_d;
    end
  end

  lfsr_period_ctr #(
    .CNT_W (CNT_W)
  ) u_period_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr_s),
    .step_i   (adv_s),
    .hit_i    (hit_s),
    .period_o (period_o),
    .wrap_o   (wrap_o)
  );

  assign q_o      = q_q;
  assign lockup_o = lockup_q;

endmodule

// File: tb/tb_lfsr_galois_param.sv
// Bench for lfsr_galois_param: constant vector table, hand sequences and a random run against a model.
module tb_lfsr_galois_param;

  localparam logic [5:0] POLY_C = 6'h08;
  localparam logic [5:0] SEED_C = 6'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, ld;
  logic [5:0]  ld_val, din;
  logic [5:0]  q, q3;
  logic        lockup, wrap, lockup3, wrap3;
  logic [15:0] period;
  logic [2:0]  period3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_galois_param dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .ld_i(ld), .ld_val_i(ld_val),
`ifdef LFSR_MISR_EN
    .din_i(din),
`endif
    .q_o(q), .lockup_o(lockup), .wrap_o(wrap), .period_o(period)
  );

  lfsr_galois_param #(.CNT_W(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .ld_i(ld), .ld_val_i(ld_val),
`ifdef LFSR_MISR_EN
    .din_i(din),
`endif
    .q_o(q3), .lockup_o(lockup3), .wrap_o(wrap3), .period_o(period3)
  );

  // Reference model: state, reference point and an unbounded step count.
  logic [5:0] m_q, m_ref;
  int         m_steps, m_period, m_period3;
  logic       m_wrap, m_lockup;

  function automatic logic [5:0] ref_step(input logic [5:0] s);
    int v;
    v = (int'(s) * 2) % 64;
    if (int'(s) >= 32) v = v ^ (int'(POLY_C & 6'h3E) | 1);
    return v[5:0];
  endfunction

  task automatic model_reset();
    m_q = SEED_C; m_ref = SEED_C; m_steps = 0;
    m_period = 0; m_period3 = 0; m_wrap = 1'b0; m_lockup = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [5:0] lv, input logic [5:0] d);
    logic [5:0] nxt;
    logic       lock;
    m_wrap = 1'b0; m_lockup = 1'b0;
    nxt = ref_step(m_q);
`ifdef LFSR_MISR_EN
    nxt  = nxt ^ d;
    lock = (nxt == 6'h00);
`else
    lock = (m_q == 6'h00);
`endif
    if (l) begin
      m_q = lv; m_ref = lv; m_steps = 0;
    end else if (e && lock) begin
      m_q = SEED_C; m_ref = SEED_C; m_steps = 0; m_lockup = 1'b1;
    end else if (e) begin
      m_q = nxt;
      m_steps = m_steps + 1;
      if (nxt == m_ref) begin
        m_wrap    = 1'b1;
        m_period  = (m_steps > 65535) ? 65535 : m_steps;
        m_period3 = (m_steps > 7) ? 7 : m_steps;
        m_steps   = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".q"},       32'(q),       32'(m_q));
    chk({tag, ".lockup"},  32'(lockup),  32'(m_lockup));
    chk({tag, ".wrap"},    32'(wrap),    32'(m_wrap));
    chk({tag, ".period"},  32'(period),  32'(m_period));
    chk({tag, ".q3"},      32'(q3),      32'(m_q));
    chk({tag, ".wrap3"},   32'(wrap3),   32'(m_wrap));
    chk({tag, ".lockup3"}, 32'(lockup3), 32'(m_lockup));
    chk({tag, ".period3"}, 32'(period3), 32'(m_period3));
  endtask

  task automatic cyc(input logic e, input logic l, input logic [5:0] lv, input logic [5:0] d);
    en = e; ld = l; ld_val = lv; din = d;
    @(posedge clk);
    model_edge(e, l, lv, d);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ld = 1'b0; ld_val = 6'h00; din = 6'h00;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic        ld;
    logic [5:0]  ldv;
    logic [5:0]  eq;
    logic        ew;
    logic        el;
    logic [15:0] ep;
    logic [2:0]  ep3;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic e, input logic l, input logic [5:0] lv, input logic [5:0] eq,
                              input logic ew, input logic el, input logic [15:0] ep, input logic [2:0] ep3);
    vec_t v;
    v.en = e; v.ld = l; v.ldv = lv; v.eq = eq; v.ew = ew; v.el = el; v.ep = ep; v.ep3 = ep3;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [5:0] seq [9];
    int         wrap_at;
    logic       e, l;
    logic [5:0] lv, d;

    seq = '{6'h37, 6'h27, 6'h07, 6'h0E, 6'h1C, 6'h38, 6'h39, 6'h3B, 6'h3F};

    // Full period from reset, then a load of 0E, then a zero load recovered by lock-up.
    for (int i = 0; i < 9; i++)
      add(1'b1, 1'b0, 6'h00, seq[i], i == 8, 1'b0, (i == 8) ? 16'd9 : 16'd0, (i == 8) ? 3'd7 : 3'd0);
    add(1'b0, 1'b1, 6'h0E, 6'h0E, 1'b0, 1'b0, 16'd9, 3'd7);
    for (int i = 0; i < 9; i++)
      add(1'b1, 1'b0, 6'h00, seq[(4 + i) % 9], i == 8, 1'b0, 16'd9, 3'd7);
    add(1'b0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 16'd9, 3'd7);
    add(1'b1, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b1, 16'd9, 3'd7);
    for (int i = 0; i < 9; i++)
      add(1'b1, 1'b0, 6'h00, seq[i], i == 8, 1'b0, 16'd9, 3'd7);
    add(1'b0, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 16'd9, 3'd7);

    do_reset();
    chk("reset.q", 32'(q), 32'h3F);
    chk("reset.period", 32'(period), 32'h0);
    chk("reset.pulses", {30'd0, wrap, lockup}, 32'h0);
    chk_model("reset");

    foreach (tbl[k]) begin
      cyc(tbl[k].en, tbl[k].ld, tbl[k].ldv, 6'h00);
      chk($sformatf("vec%0d.q", k),       32'(q),       32'(tbl[k].eq));
      chk($sformatf("vec%0d.wrap", k),    32'(wrap),    32'(tbl[k].ew));
      chk($sformatf("vec%0d.lockup", k),  32'(lockup),  32'(tbl[k].el));
      chk($sformatf("vec%0d.period", k),  32'(period),  32'(tbl[k].ep));
      chk($sformatf("vec%0d.period3", k), 32'(period3), 32'(tbl[k].ep3));
      chk_model($sformatf("vec%0d", k));
    end

    // en toggling: only enabled edges advance; the 9th enabled edge wraps.
    wrap_at = -1;
    for (int i = 0; i < 18; i++) begin
      cyc(i % 2 == 0, 1'b0, 6'h00, 6'h00);
      if (wrap === 1'b1 && wrap_at < 0) wrap_at = i;
      chk_model($sformatf("toggle%0d", i));
    end
    chk("toggle.wrap_at", 32'(wrap_at), 32'd16);
    chk("toggle.q", 32'(q), 32'h3F);
    chk("toggle.period", 32'(period), 32'd9);

    // Asynchronous reset four steps into a run.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 6'h00, 6'h00);
      chk_model($sformatf("prerst%0d", i));
    end
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.q", 32'(q), 32'h3F);
    chk("midrst.period", 32'(period), 32'h0);
    chk_model("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, 6'h00, 6'h00);
      chk_model($sformatf("postrst%0d", i));
    end
    chk("postrst.wrap", 32'(wrap), 32'h1);
    chk("postrst.period", 32'(period), 32'd9);

`ifdef LFSR_MISR_EN
    do_reset();
    cyc(1'b1, 1'b0, 6'h00, 6'h01);
    chk("misr.q", 32'(q), 32'h36);
    chk_model("misr1");
    do_reset();
    cyc(1'b1, 1'b0, 6'h00, 6'h37);
    chk("misr.lock_q", 32'(q), 32'h3F);
    chk("misr.lockup", 32'(lockup), 32'h1);
    chk_model("misr2");
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom % 10) < 7;
      l  = ($urandom % 20) == 0;
      lv = (($urandom % 4) == 0) ? 6'h00 : 6'($urandom);
`ifdef LFSR_MISR_EN
      d  = (($urandom % 4) == 0) ? 6'($urandom) : 6'h00;
`else
      d  = 6'h00;
`endif
      cyc(e, l, lv, d);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
